state_sequencer: RTL and testbench

STATE_SEQUENCER -- requirements
Module: state_sequencer

---
 rtl/state_sequencer.sv | 126 ++++++++++++
 tb/tb_state_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// Multi-cycle CPU state sequencer: fetch, one or two execute states, halt.
// Owns the PC, the instruction register and the branch delay-slot bookkeeping.
//
// state       | meaning
// FETCH_INSTR | read instruction at pc (halt instead if pc is zero)
// EXEC1_INSTR | execute; sample branch outcome, maybe need a second cycle
// EXEC2_INSTR | data access for load/store, stalls on waitrequest
// HALTED      | absorbing until reset; no bus activity
module state_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        needs_exec2,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [2:0]  state,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch_read,
  output logic [31:0] fetch_address,
  output logic        active
);

  typedef enum logic [2:0] {
    FETCH_INSTR = 3'd0,
    EXEC1_INSTR = 3'd1,
    EXEC2_INSTR = 3'd2,
    HALTED      = 3'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic        delay_pending_q, delay_pending_d;
  logic        active_q, active_d;
  logic        pc_update;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    saved_target_d  = saved_target_q;
    delay_pending_d = delay_pending_q;
    active_d        = active_q;
    pc_update       = 1'b0;

    case (state_q)
      FETCH_INSTR: begin
        if (pc_q == 32'h0) begin
          state_d  = HALTED;
          active_d = 1'b0;
        end else if (!waitrequest) begin
          instr_d = readdata;
          state_d = EXEC1_INSTR;
        end
      end
      EXEC1_INSTR: begin
        // A branch sitting in a delay slot is ignored: the first target wins.
        if (branch_taken && !delay_pending_q) begin
          delay_pending_d = 1'b1;
          saved_target_d  = branch_target;
        end
        if (needs_exec2) begin
          state_d = EXEC2_INSTR;
        end else begin
          state_d   = FETCH_INSTR;
          pc_update = 1'b1;
        end
      end
      EXEC2_INSTR: begin
        if (!waitrequest) begin
          state_d   = FETCH_INSTR;
          pc_update = 1'b1;
        end
      end
      HALTED: begin
        active_d = 1'b0;
      end
      default: begin
        state_d  = HALTED;
        active_d = 1'b0;
      end
    endcase

    // Only reached with delay_pending_q=0 when a new branch is being recorded,
    // so a fresh branch never redirects the update it shares an edge with.
    if (pc_update) begin
      if (delay_pending_q) begin
        pc_d            = saved_target_q;
        delay_pending_d = 1'b0;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= FETCH_INSTR;
      pc_q            <= RESET_VECTOR;
      instr_q         <= 32'h0;
      saved_target_q  <= 32'h0;
      delay_pending_q <= 1'b0;
      active_q        <= 1'b1;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      saved_target_q  <= saved_target_d;
      delay_pending_q <= delay_pending_d;
      active_q        <= active_d;
    end
  end

  assign state         = state_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign active        = active_q;
  assign fetch_read    = (state_q == FETCH_INSTR) && (pc_q != 32'h0);
  assign fetch_address = pc_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: directed vector table, async-reset sequences,
// then random traffic checked against an instruction-level reference model.
module tb_state_sequencer;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        needs_exec2;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [2:0]  state;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fetch_read;
  logic [31:0] fetch_address;
  logic        active;

  int n_cmp = 0;
  int n_err = 0;

  state_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .needs_exec2  (needs_exec2),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .state        (state),
    .instr        (instr),
    .pc           (pc),
    .fetch_read   (fetch_read),
    .fetch_address(fetch_address),
    .active       (active)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the architectural view (stage, pc, ir, branch shadow).
  int          ref_stage;   // 0 fetch, 1 exec1, 2 exec2, 3 halted
  logic [31:0] ref_pc, ref_ir, ref_target;
  bit          ref_pending, ref_alive;

  task automatic ref_reset();
    ref_stage = 0; ref_pc = RV; ref_ir = 0; ref_target = 0;
    ref_pending = 0; ref_alive = 1;
  endtask

  task automatic drive_cycle(input logic wr, input logic [31:0] rd, input logic ne2,
                             input logic bt, input logic [31:0] tgt);
    int          n_stage;
    logic [31:0] n_pc, n_ir, n_target;
    bit          n_pending, n_alive, retire, exp_fr;
    waitrequest = wr; readdata = rd; needs_exec2 = ne2;
    branch_taken = bt; branch_target = tgt;
    exp_fr = (ref_stage == 0) && (ref_pc != 0);
    chk("fetch_read", 32'(fetch_read), 32'(exp_fr));
    if (exp_fr) chk("fetch_address", fetch_address, ref_pc);
    n_stage = ref_stage; n_pc = ref_pc; n_ir = ref_ir; n_target = ref_target;
    n_pending = ref_pending; n_alive = ref_alive;
    retire = (ref_stage == 1 && !ne2) || (ref_stage == 2 && !wr);
    if (ref_stage == 0) begin
      if (ref_pc == 0) begin n_stage = 3; n_alive = 0; end
      else if (!wr) begin n_ir = rd; n_stage = 1; end
    end else if (ref_stage == 1) begin
      n_stage = ne2 ? 2 : 0;
      if (bt && !ref_pending) begin n_pending = 1; n_target = tgt; end
    end else if (ref_stage == 2 && !wr) begin
      n_stage = 0;
    end
    if (retire) begin
      if (ref_pending) begin n_pc = ref_target; n_pending = 0; end
      else n_pc = ref_pc + 32'd4;
    end
    @(posedge clk); #1;
    ref_stage = n_stage; ref_pc = n_pc; ref_ir = n_ir; ref_target = n_target;
    ref_pending = n_pending; ref_alive = n_alive;
    chk("state", 32'(state), 32'(ref_stage));
    chk("pc", pc, ref_pc);
    chk("instr", instr, ref_ir);
    chk("active", 32'(active), 32'(ref_alive));
  endtask

  // Asserted between edges; values must change with no clock edge.
  task automatic async_reset(input string nm);
    #2 reset_n = 1'b0;
    #1;
    ref_reset();
    chk({nm, "_state"}, 32'(state), 32'd0);
    chk({nm, "_pc"}, pc, RV);
    chk({nm, "_instr"}, instr, 32'h0);
    chk({nm, "_active"}, 32'(active), 32'd1);
    chk({nm, "_fetch_read"}, 32'(fetch_read), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic        ne2;
    logic        bt;
    logic [31:0] tgt;
    logic        e_fr;
    logic [2:0]  e_st;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_act;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(logic wr, logic [31:0] rd, logic ne2, logic bt, logic [31:0] tgt,
                               logic e_fr, logic [2:0] e_st, logic [31:0] e_pc,
                               logic [31:0] e_instr, logic e_act);
    vec_t v;
    v.wr = wr; v.rd = rd; v.ne2 = ne2; v.bt = bt; v.tgt = tgt;
    v.e_fr = e_fr; v.e_st = e_st; v.e_pc = e_pc; v.e_instr = e_instr; v.e_act = e_act;
    return v;
  endfunction

  initial begin
    logic [31:0] cur_pc;
    int          halted_cycles;

    reset_n = 1'b0; waitrequest = 0; readdata = 0; needs_exec2 = 0;
    branch_taken = 0; branch_target = 0;

    //          wr  rd            ne2 bt tgt           fr st   pc            instr         act
    vq.push_back(mkv(0, 32'h24020005, 0, 0, 32'h0,        1, 3'd1, 32'hBFC00000, 32'h24020005, 1));
    vq.push_back(mkv(0, 32'h0,        0, 0, 32'h0,        0, 3'd0, 32'hBFC00004, 32'h24020005, 1));
    vq.push_back(mkv(1, 32'hDEAD0001, 0, 0, 32'h0,        1, 3'd0, 32'hBFC00004, 32'h24020005, 1));
    vq.push_back(mkv(1, 32'hDEAD0002, 0, 0, 32'h0,        1, 3'd0, 32'hBFC00004, 32'h24020005, 1));
    vq.push_back(mkv(1, 32'hDEAD0003, 0, 0, 32'h0,        1, 3'd0, 32'hBFC00004, 32'h24020005, 1));
    vq.push_back(mkv(0, 32'h8C430000, 0, 0, 32'h0,        1, 3'd1, 32'hBFC00004, 32'h8C430000, 1));
    vq.push_back(mkv(1, 32'h0,        1, 0, 32'h0,        0, 3'd2, 32'hBFC00004, 32'h8C430000, 1));
    vq.push_back(mkv(1, 32'h0,        0, 0, 32'h0,        0, 3'd2, 32'hBFC00004, 32'h8C430000, 1));
    vq.push_back(mkv(1, 32'h0,        0, 0, 32'h0,        0, 3'd2, 32'hBFC00004, 32'h8C430000, 1));
    vq.push_back(mkv(0, 32'h0,        0, 0, 32'h0,        0, 3'd0, 32'hBFC00008, 32'h8C430000, 1));
    vq.push_back(mkv(0, 32'h0,        0, 0, 32'h0,        1, 3'd1, 32'hBFC00008, 32'h00000000, 1));
    vq.push_back(mkv(0, 32'h0,        0, 0, 32'h0,        0, 3'd0, 32'hBFC0000C, 32'h00000000, 1));
    vq.push_back(mkv(0, 32'h11111111, 0, 0, 32'h0,        1, 3'd1, 32'hBFC0000C, 32'h11111111, 1));
    vq.push_back(mkv(0, 32'h0,        0, 0, 32'h0,        0, 3'd0, 32'hBFC00010, 32'h11111111, 1));
    vq.push_back(mkv(0, 32'h10000040, 0, 0, 32'h0,        1, 3'd1, 32'hBFC00010, 32'h10000040, 1));
    vq.push_back(mkv(0, 32'h0,        0, 1, 32'hBFC00100, 0, 3'd0, 32'hBFC00014, 32'h10000040, 1));
    vq.push_back(mkv(0, 32'h22222222, 0, 0, 32'h0,        1, 3'd1, 32'hBFC00014, 32'h22222222, 1));
    vq.push_back(mkv(0, 32'h0,        0, 1, 32'hBFC00200, 0, 3'd0, 32'hBFC00100, 32'h22222222, 1));
    vq.push_back(mkv(0, 32'h33333333, 0, 1, 32'h0,        1, 3'd1, 32'hBFC00100, 32'h33333333, 1));
    vq.push_back(mkv(0, 32'h0,        0, 0, 32'h0,        0, 3'd0, 32'hBFC00104, 32'h33333333, 1));
    vq.push_back(mkv(0, 32'h03E00008, 0, 0, 32'h0,        1, 3'd1, 32'hBFC00104, 32'h03E00008, 1));
    vq.push_back(mkv(0, 32'h0,        0, 1, 32'h0,        0, 3'd0, 32'hBFC00108, 32'h03E00008, 1));
    vq.push_back(mkv(0, 32'h44444444, 0, 0, 32'h0,        1, 3'd1, 32'hBFC00108, 32'h44444444, 1));
    vq.push_back(mkv(0, 32'h0,        1, 0, 32'h0,        0, 3'd2, 32'hBFC00108, 32'h44444444, 1));
    vq.push_back(mkv(0, 32'h0,        0, 0, 32'h0,        0, 3'd0, 32'h00000000, 32'h44444444, 1));
    vq.push_back(mkv(0, 32'h55555555, 0, 0, 32'h0,        0, 3'd3, 32'h00000000, 32'h44444444, 0));
    vq.push_back(mkv(1, 32'h66666666, 0, 0, 32'h0,        0, 3'd3, 32'h00000000, 32'h44444444, 0));
    vq.push_back(mkv(0, 32'h77777777, 1, 1, 32'h12345678, 0, 3'd3, 32'h00000000, 32'h44444444, 0));

    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, RV);
    chk("rst_instr", instr, 32'h0);
    chk("rst_active", 32'(active), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    chk("first_fetch_read", 32'(fetch_read), 32'd1);
    chk("first_fetch_address", fetch_address, 32'hBFC00000);

    cur_pc = RV;
    foreach (vq[i]) begin
      waitrequest = vq[i].wr; readdata = vq[i].rd; needs_exec2 = vq[i].ne2;
      branch_taken = vq[i].bt; branch_target = vq[i].tgt;
      chk($sformatf("v%0d_fetch_read", i), 32'(fetch_read), 32'(vq[i].e_fr));
      if (vq[i].e_fr) chk($sformatf("v%0d_fetch_address", i), fetch_address, cur_pc);
      @(posedge clk); #1;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vq[i].e_st));
      chk($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
      chk($sformatf("v%0d_instr", i), instr, vq[i].e_instr);
      chk($sformatf("v%0d_active", i), 32'(active), 32'(vq[i].e_act));
      cur_pc = vq[i].e_pc;
    end

    // Leave HALTED via reset, stall a fetch, reset mid-stall, then restart.
    async_reset("halt_rst");
    ref_reset();
    drive_cycle(1, 32'hAAAA0000, 0, 0, 0);
    drive_cycle(1, 32'hAAAA0001, 0, 0, 0);
    async_reset("stall_rst");
    drive_cycle(0, 32'hAAAA0002, 0, 0, 0);
    chk("restart_instr", instr, 32'hAAAA0002);

    // Reset asserted between edges while in EXEC2.
    drive_cycle(0, 32'h0, 1, 0, 0);
    drive_cycle(1, 32'h0, 0, 0, 0);
    chk("exec2_before_rst", 32'(state), 32'd2);
    async_reset("exec2_rst");

    // Wraparound of pc+4 at the top of the address space.
    drive_cycle(0, 32'h1, 0, 0, 0);
    drive_cycle(0, 32'h0, 0, 1, 32'hFFFFFFFC);
    drive_cycle(0, 32'h2, 0, 0, 0);
    drive_cycle(0, 32'h0, 0, 0, 0);
    chk("jump_top", pc, 32'hFFFFFFFC);
    drive_cycle(0, 32'h3, 0, 0, 0);
    drive_cycle(0, 32'h0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    drive_cycle(0, 32'h4, 0, 0, 0);
    chk("wrap_halt", 32'(state), 32'd3);
    async_reset("wrap_rst");

    halted_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 40) == 0) ? 32'h0 : ($urandom & 32'hFFFFFFFC);
      drive_cycle(($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), tgt);
      halted_cycles = (ref_stage == 3) ? halted_cycles + 1 : 0;
      if (halted_cycles >= 3 || $urandom_range(0, 299) == 0) begin
        async_reset("rand_rst");
        halted_cycles = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
